// File: rtl/kros_pkg.sv
// Shared KROS pushbutton definitions: button encoding, FSM states, default timing.
package kros_pkg;

   localparam int unsigned BTN_W   = 2;
   localparam int unsigned COUNT_W = 4;
   localparam int unsigned NUM_BTN = 4;

   localparam logic [BTN_W-1:0] BTN_FREQ_UP = 2'd0;
   localparam logic [BTN_W-1:0] BTN_FREQ_DN = 2'd1;
   localparam logic [BTN_W-1:0] BTN_SEQ_UP  = 2'd2;
   localparam logic [BTN_W-1:0] BTN_SEQ_DN  = 2'd3;

   localparam int unsigned DEF_HOLD_CYCLES = 50;
   localparam int unsigned DEF_GAP_CYCLES  = 100;
   localparam int unsigned DEF_CNT_W       = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Active-low line vector with only the selected button pulled low.
   function automatic logic [NUM_BTN-1:0] btn_mask(input logic [BTN_W-1:0] btn);
      logic [NUM_BTN-1:0] m;
      m      = '1;
      m[btn] = 1'b0;
      return m;
   endfunction

endpackage

// File: rtl/pb_press_gen_if.sv
// Command handshake between a press source and pb_press_gen.
interface pb_press_gen_if;
   import kros_pkg::*;

   logic               cmd_valid;
   logic               cmd_ready;
   logic [BTN_W-1:0]   cmd_btn;
   logic [COUNT_W-1:0] cmd_count;
   logic               abort;

   modport master (
      output cmd_valid,
      output cmd_btn,
      output cmd_count,
      output abort,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_btn,
      input  cmd_count,
      input  abort,
      output cmd_ready
   );
endinterface

// File: rtl/pb_phase_timer.sv
// Loadable down-counter shared by the PRESS and GAP phases.
module pb_phase_timer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero_c
);

   logic [CNT_W-1:0] cnt_q;

   // Load takes priority; decrement stops at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/pb_press_gen.sv
// KROS pushbutton transmitter: turns a valid/ready command into timed active-low presses.
module pb_press_gen
   import kros_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic               CLK_50,
   input  logic               reset,
   pb_press_gen_if.slave      cmd,
   output logic               pb_freq_up,
   output logic               pb_freq_dn,
   output logic               pb_seq_up,
   output logic               pb_seq_dn,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] press_cnt
);

   // Timer counts down to zero, so a phase of N cycles loads N-1.
   localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [COUNT_W-1:0] CNT_MAX = '1;

   state_t               state_q, state_n;
   logic [BTN_W-1:0]     btn_q, btn_n;
   logic [COUNT_W-1:0]   rem_q, rem_n;
   logic [COUNT_W-1:0]   press_cnt_n;
   logic                 done_n;
   logic [NUM_BTN-1:0]   pb_q, pb_n;
   logic                 ready_q;
   logic                 busy_q;

   logic                 tmr_load;
   logic                 tmr_en;
   logic [CNT_W-1:0]     tmr_val;
   logic                 tmr_zero_c;

   pb_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (CLK_50),
      .reset    (reset),
      .load     (tmr_load),
      .en       (tmr_en),
      .load_val (tmr_val),
      .zero_c   (tmr_zero_c)
   );

   // State and registered outputs; every output follows the next state.
   always_ff @(posedge CLK_50) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         btn_q     <= '0;
         rem_q     <= '0;
         press_cnt <= '0;
         done      <= 1'b0;
         pb_q      <= '1;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_n;
         btn_q     <= btn_n;
         rem_q     <= rem_n;
         press_cnt <= press_cnt_n;
         done      <= done_n;
         pb_q      <= pb_n;
         ready_q   <= (state_n == ST_IDLE);
         busy_q    <= (state_n != ST_IDLE);
      end
   end

   // Next-state, timer control and next output values.
   always_comb begin
      state_n     = state_q;
      btn_n       = btn_q;
      rem_n       = rem_q;
      press_cnt_n = press_cnt;
      done_n      = 1'b0;
      tmr_load    = 1'b0;
      tmr_en      = 1'b0;
      tmr_val     = HOLD_LD;

      unique case (state_q)
         ST_IDLE: begin
            // abort is meaningless here; a pending command always wins
            if (cmd.cmd_valid) begin
               press_cnt_n = '0;
               if (cmd.cmd_count == '0) begin
                  done_n = 1'b1;
               end else begin
                  btn_n    = cmd.cmd_btn;
                  rem_n    = cmd.cmd_count;
                  tmr_load = 1'b1;
                  tmr_val  = HOLD_LD;
                  state_n  = ST_PRESS;
               end
            end
         end
         ST_PRESS: begin
            if (cmd.abort) begin
               // partial hold is dropped, not counted
               state_n = ST_IDLE;
               done_n  = 1'b1;
            end else if (tmr_zero_c) begin
               if (press_cnt != CNT_MAX) begin
                  press_cnt_n = press_cnt + COUNT_W'(1);
               end
               if (rem_q != '0) begin
                  rem_n = rem_q - COUNT_W'(1);
               end
               tmr_load = 1'b1;
               tmr_val  = GAP_LD;
               state_n  = ST_GAP;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_GAP: begin
            if (cmd.abort) begin
               state_n = ST_IDLE;
               done_n  = 1'b1;
            end else if (tmr_zero_c) begin
               if (rem_q != '0) begin
                  tmr_load = 1'b1;
                  tmr_val  = HOLD_LD;
                  state_n  = ST_PRESS;
               end else begin
                  state_n = ST_IDLE;
                  done_n  = 1'b1;
               end
            end else begin
               tmr_en = 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      pb_n = '1;
      if (state_n == ST_PRESS) begin
         pb_n = btn_mask(btn_n);
      end
   end

   assign cmd.cmd_ready = ready_q;
   assign busy          = busy_q;
   assign pb_freq_up    = pb_q[BTN_FREQ_UP];
   assign pb_freq_dn    = pb_q[BTN_FREQ_DN];
   assign pb_seq_up     = pb_q[BTN_SEQ_UP];
   assign pb_seq_dn     = pb_q[BTN_SEQ_DN];

endmodule
